// File: rtl/dmem_ctrl_if.sv
// Request/response bus between the data cache stage and dmem_ctrl.
// The cache stage drives the master side; the controller is the slave.
interface dmem_ctrl_if;
    logic        dm_en_i;
    logic        dm_wen_i;
    logic [31:0] dm_addr_i;
    logic [31:0] dm_din_i;
    logic        dm_busy_o;
    logic [31:0] dm_dout_o;

    modport master (
        output dm_en_i, dm_wen_i, dm_addr_i, dm_din_i,
        input  dm_busy_o, dm_dout_o
    );

    modport slave (
        input  dm_en_i, dm_wen_i, dm_addr_i, dm_din_i,
        output dm_busy_o, dm_dout_o
    );
endinterface

// File: rtl/dmem_ctrl.sv
// Data-memory controller: single-word word-addressed RAM with programmable wait
// states signalled on dm_busy_o, plus free-running read/write access counters.
module dmem_ctrl #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    dmem_ctrl_if.slave  dm,
    output logic [31:0] rd_count_o,
    output logic [31:0] wr_count_o
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait_cycles
        $error("dmem_ctrl: WAIT_CYCLES must be within 0..15");
    end

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] idx;
        logic                  wen;
        logic [31:0]           din;
    } req_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q;
    req_t        req_q, req_in, req_act;
    logic        accept, complete;
    logic [31:0] dout_q, rd_cnt_q, wr_cnt_q;
    logic [31:0] mem [DEPTH];

    // Byte-offset bits and bits above the index are ignored, so addresses alias.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{dm.dm_addr_i[31:ADDR_WIDTH+2], dm.dm_addr_i[1:0]};

    assign req_in = '{idx: dm.dm_addr_i[ADDR_WIDTH+1:2],
                      wen: dm.dm_wen_i,
                      din: dm.dm_din_i};

    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // NOTE: each always_comb assigns defaults first, so no path leaves a
    // variable unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (dm.dm_en_i && WAIT_CYCLES != 0) state_d = BUSY;
            BUSY:    if (cnt_q == 4'd1) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // With zero wait states the access completes at its acceptance edge, using
    // the live bus fields; otherwise only the latched copy is used.
    always_comb begin
        accept   = 1'b0;
        complete = 1'b0;
        req_act  = req_q;
        case (state_q)
            IDLE: begin
                accept = dm.dm_en_i;
                if (WAIT_CYCLES == 0) begin
                    complete = dm.dm_en_i;
                    req_act  = req_in;
                end
            end
            BUSY:    complete = (cnt_q == 4'd1);
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q    <= '0;
            req_q    <= '0;
            dout_q   <= '0;
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            if (accept) begin
                req_q <= req_in;
                cnt_q <= 4'(WAIT_CYCLES);
            end else if (state_q == BUSY) begin
                cnt_q <= cnt_q - 4'd1;
            end
            if (complete && !req_act.wen) begin
                dout_q   <= mem[req_act.idx];
                rd_cnt_q <= rd_cnt_q + 32'd1;
            end
            if (complete && req_act.wen) begin
                wr_cnt_q <= wr_cnt_q + 32'd1;
            end
        end
    end

    // NOTE: the array has no reset so it maps onto plain RAM; the write is gated
    // by rst_i so nothing commits while the controller is held in reset.
    always_ff @(posedge clk_i) begin
        if (complete && req_act.wen && !rst_i) begin
            mem[req_act.idx] <= req_act.din;
        end
    end

    assign dm.dm_busy_o = (state_q == BUSY);
    assign dm.dm_dout_o = dout_q;
    assign rd_count_o   = rd_cnt_q;
    assign wr_count_o   = wr_cnt_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: three instances with 2, 0 and 4 wait states,
// each stimulated with hand-computed expected values.
module tb_dmem_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_a;
    logic        rst_b;
    logic [31:0] rd2, wr2, rd0, wr0, rd4, wr4;
    int          n_vec = 0;
    int          n_err = 0;

    dmem_ctrl_if if_w2 ();
    dmem_ctrl_if if_w0 ();
    dmem_ctrl_if if_w4 ();

    dmem_ctrl #(.ADDR_WIDTH(10), .WAIT_CYCLES(2)) u_w2 (
        .clk_i(clk_i), .rst_i(rst_a), .dm(if_w2), .rd_count_o(rd2), .wr_count_o(wr2));
    dmem_ctrl #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) u_w0 (
        .clk_i(clk_i), .rst_i(rst_a), .dm(if_w0), .rd_count_o(rd0), .wr_count_o(wr0));
    dmem_ctrl #(.ADDR_WIDTH(10), .WAIT_CYCLES(4)) u_w4 (
        .clk_i(clk_i), .rst_i(rst_b), .dm(if_w4), .rd_count_o(rd4), .wr_count_o(wr4));

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // One access on the 2-wait instance, checking the busy window shape.
    task automatic w2_access(input string tag, input logic wen, input logic [31:0] addr,
                             input logic [31:0] din);
        if_w2.dm_en_i   = 1'b1;
        if_w2.dm_wen_i  = wen;
        if_w2.dm_addr_i = addr;
        if_w2.dm_din_i  = din;
        step();
        if_w2.dm_en_i = 1'b0;
        check({tag, " busy c1"}, 32'(if_w2.dm_busy_o), 32'd1);
        step();
        check({tag, " busy c2"}, 32'(if_w2.dm_busy_o), 32'd1);
        step();
        check({tag, " busy done"}, 32'(if_w2.dm_busy_o), 32'd0);
    endtask

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        if_w2.dm_en_i = 1'b0; if_w2.dm_wen_i = 1'b0; if_w2.dm_addr_i = '0; if_w2.dm_din_i = '0;
        if_w0.dm_en_i = 1'b0; if_w0.dm_wen_i = 1'b0; if_w0.dm_addr_i = '0; if_w0.dm_din_i = '0;
        if_w4.dm_en_i = 1'b0; if_w4.dm_wen_i = 1'b0; if_w4.dm_addr_i = '0; if_w4.dm_din_i = '0;

        // Reset held for 3 cycles while requests toggle.
        for (int i = 0; i < 3; i++) begin
            if_w2.dm_en_i  = (i % 2 == 0);
            if_w2.dm_wen_i = (i == 1);
            if_w0.dm_en_i  = (i % 2 == 0);
            if_w0.dm_wen_i = (i == 0);
            step();
            check("rst busy w2", 32'(if_w2.dm_busy_o), 32'd0);
            check("rst dout w2", if_w2.dm_dout_o, 32'd0);
            check("rst rd w2", rd2, 32'd0);
            check("rst wr w2", wr2, 32'd0);
            check("rst dout w0", if_w0.dm_dout_o, 32'd0);
            check("rst rd w0", rd0, 32'd0);
            check("rst wr w0", wr0, 32'd0);
        end
        if_w2.dm_en_i = 1'b0; if_w2.dm_wen_i = 1'b0;
        if_w0.dm_en_i = 1'b0; if_w0.dm_wen_i = 1'b0;
        rst_a = 1'b0;
        rst_b = 1'b0;
        step();

        // Two wait states: write then read back.
        w2_access("w2 wr 0x10", 1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
        check("w2 wr count", wr2, 32'd1);
        check("w2 dout after wr", if_w2.dm_dout_o, 32'd0);
        w2_access("w2 rd 0x10", 1'b0, 32'h0000_0010, 32'h0);
        check("w2 rd data", if_w2.dm_dout_o, 32'hDEAD_BEEF);
        check("w2 rd count", rd2, 32'd1);
        w2_access("w2 wr 0x20", 1'b1, 32'h0000_0020, 32'h2020_2020);
        check("w2 wr count 2", wr2, 32'd2);
        w2_access("w2 rd 0x20", 1'b0, 32'h0000_0020, 32'h0);
        check("w2 rd 0x20 data", if_w2.dm_dout_o, 32'h2020_2020);

        // Inputs change during the busy window of a read of 0x10.
        if_w2.dm_en_i = 1'b1; if_w2.dm_wen_i = 1'b0; if_w2.dm_addr_i = 32'h10;
        step();
        check("ign busy c1", 32'(if_w2.dm_busy_o), 32'd1);
        if_w2.dm_addr_i = 32'h20; if_w2.dm_wen_i = 1'b1; if_w2.dm_din_i = 32'hBAD0_BAD0;
        step();
        check("ign busy c2", 32'(if_w2.dm_busy_o), 32'd1);
        if_w2.dm_en_i = 1'b0;
        step();
        check("ign busy done", 32'(if_w2.dm_busy_o), 32'd0);
        check("ign rd data", if_w2.dm_dout_o, 32'hDEAD_BEEF);
        check("ign rd count", rd2, 32'd3);
        check("ign wr count", wr2, 32'd2);
        if_w2.dm_wen_i = 1'b0;
        w2_access("w2 rd 0x20 again", 1'b0, 32'h0000_0020, 32'h0);
        check("ign 0x20 intact", if_w2.dm_dout_o, 32'h2020_2020);
        check("w2 rd count final", rd2, 32'd4);

        // Zero wait states: streaming writes then reads.
        if_w0.dm_en_i = 1'b1; if_w0.dm_wen_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if_w0.dm_addr_i = 32'(i * 4);
            if_w0.dm_din_i  = 32'(i + 1);
            step();
            check("w0 wr busy", 32'(if_w0.dm_busy_o), 32'd0);
            check("w0 wr count", wr0, 32'(i + 1));
        end
        if_w0.dm_wen_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if_w0.dm_addr_i = 32'(i * 4);
            step();
            check("w0 rd busy", 32'(if_w0.dm_busy_o), 32'd0);
            check("w0 rd data", if_w0.dm_dout_o, 32'(i + 1));
        end
        check("w0 rd count", rd0, 32'd3);
        check("w0 wr count total", wr0, 32'd3);

        // Aliasing and misalignment: 0x1003 maps to word 0.
        if_w0.dm_wen_i = 1'b1; if_w0.dm_addr_i = 32'h0000_1003; if_w0.dm_din_i = 32'hA5A5_A5A5;
        step();
        if_w0.dm_wen_i = 1'b0; if_w0.dm_addr_i = 32'h0000_0000;
        step();
        if_w0.dm_en_i = 1'b0;
        check("alias rd data", if_w0.dm_dout_o, 32'hA5A5_A5A5);
        check("alias counts", {rd0[15:0], wr0[15:0]}, {16'd4, 16'd4});

        // Four wait states: preload 0x40, then abort a write with reset.
        if_w4.dm_en_i = 1'b1; if_w4.dm_wen_i = 1'b1;
        if_w4.dm_addr_i = 32'h40; if_w4.dm_din_i = 32'h0BAD_F00D;
        step();
        if_w4.dm_en_i = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check("w4 preload wr count", wr4, 32'd1);
        check("w4 preload idle", 32'(if_w4.dm_busy_o), 32'd0);
        if_w4.dm_en_i = 1'b1; if_w4.dm_din_i = 32'h1234_5678;
        step();
        if_w4.dm_en_i = 1'b0;
        check("w4 abort busy c1", 32'(if_w4.dm_busy_o), 32'd1);
        step();
        check("w4 abort busy c2", 32'(if_w4.dm_busy_o), 32'd1);
        #2 rst_b = 1'b1;
        #1;
        check("w4 async busy drop", 32'(if_w4.dm_busy_o), 32'd0);
        check("w4 async wr count", wr4, 32'd0);
        step();
        step();
        rst_b = 1'b0;
        step();
        if_w4.dm_en_i = 1'b1; if_w4.dm_wen_i = 1'b0;
        step();
        if_w4.dm_en_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("w4 rd busy", 32'(if_w4.dm_busy_o), 32'd1);
            step();
        end
        check("w4 rd busy c4", 32'(if_w4.dm_busy_o), 32'd1);
        step();
        check("w4 rd done", 32'(if_w4.dm_busy_o), 32'd0);
        check("w4 rd prior data", if_w4.dm_dout_o, 32'h0BAD_F00D);
        check("w4 rd count", rd4, 32'd1);
        check("w4 wr count after abort", wr4, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Data-memory controller directly downstream of the data cache stage.
- Accepts single-word read/write requests on the dm_* bus and stores data in an internal word-addressed RAM array.
- Inserts a programmable number of wait states, signalled through dm_busy_o; the cache stage uses dm_busy_o to stall the pipeline.
- Provides free-running read/write access counters for performance debug.

Parameters:
ADDR_WIDTH, 10, number of word-index bits; the array holds 2**ADDR_WIDTH 32-bit words
WAIT_CYCLES, 2, busy cycles per access; legal range 0..15

Ports:
clk_i  input  1  clock; all state updates on the rising edge
rst_i  input  1  asynchronous, active-high reset
dm_en_i  input  1  request valid; sampled only in IDLE
dm_wen_i  input  1  1 = write, 0 = read; qualified by dm_en_i
dm_addr_i  input  32  byte address; bits [1:0] ignored; bits [ADDR_WIDTH+1:2] index the array; upper bits ignored (aliasing)
dm_din_i  input  32  write data
dm_busy_o  output  1  high while an accepted request is in wait states
dm_dout_o  output  32  read data; holds the last completed read
rd_count_o  output  32  number of completed reads, wraps at 2**32
wr_count_o  output  32  number of completed writes, wraps at 2**32

Behaviour:
- Reset (rst_i high, asynchronous):
  - state = IDLE; dm_busy_o = 0; dm_dout_o = 0; wait counter = 0; rd_count_o = 0; wr_count_o = 0; latched request fields = 0.
  - Array contents are not reset.
  - Reset asserted mid-access aborts the access: a pending write is never committed, and neither count increments.
- States: IDLE and BUSY. dm_busy_o is a registered output, equal to (state == BUSY).
- IDLE, dm_en_i = 0: hold all outputs.
- IDLE, dm_en_i = 1 at an edge: latch the word index, dm_wen_i and dm_din_i.
  - WAIT_CYCLES = 0: the access completes at this same edge and the state stays IDLE, so one access per cycle is possible.
  - WAIT_CYCLES > 0: go to BUSY and load the counter with WAIT_CYCLES.
- BUSY:
  - dm_en_i, dm_wen_i, dm_addr_i and dm_din_i are ignored; only the latched copies are used.
  - The counter decrements at each edge. At the edge where the counter equals 1, the access completes and the state returns to IDLE.
  - dm_busy_o is therefore high for exactly WAIT_CYCLES cycles, starting the cycle after acceptance.
- Completion edge:
  - Read: dm_dout_o <= mem[index]; rd_count_o increments.
  - Write: mem[index] <= latched din; wr_count_o increments; dm_dout_o is unchanged.
- Read data is valid on dm_dout_o from the first cycle after completion, which is the first cycle dm_busy_o is low again. It holds until the next read completes.
- Back-to-back requests:
  - WAIT_CYCLES > 0: a new request is accepted at the first edge in IDLE, which is the edge after dm_busy_o falls. There is no overlap or queuing.
  - Requests presented while BUSY are dropped. The upstream stage must hold them until busy is low.
- Read-after-write to the same index returns the new data, in both the 0-wait and the multi-wait case.
- Counter wrap: 0xFFFF_FFFF + 1 = 0x0000_0000, with no saturation.
- WAIT_CYCLES outside 0..15 is illegal. Elaboration fails with an assertion.

Test Plan:
- Reset: hold rst_i high for 3 cycles, with dm_en_i toggling -> dm_busy_o = 0, dm_dout_o = 0, rd_count_o = 0 and wr_count_o = 0 throughout. Then release reset.
- WAIT_CYCLES = 2, write then read:
  - Write 0xDEADBEEF to 0x0000_0010 -> busy high for exactly 2 cycles; wr_count_o = 1; dm_dout_o unchanged.
  - Read 0x10 -> busy high for 2 cycles; dm_dout_o = 0xDEADBEEF in the first non-busy cycle; rd_count_o = 1.
- Inputs ignored while busy: during the busy window of a read of 0x10, change dm_addr_i to 0x20 and raise dm_wen_i -> dm_dout_o still returns 0x10's data, and mem[0x20] is not written.
- WAIT_CYCLES = 0 streaming:
  - Writes 0x1, 0x2, 0x3 to words 0, 1, 2 on consecutive cycles, followed by reads of words 0, 1, 2 on consecutive cycles -> dm_busy_o never asserts; dm_dout_o = 0x1, 0x2, 0x3 on successive cycles; counts are 3 and 3.
- Aliasing and misalignment (ADDR_WIDTH = 10):
  - Write 0xA5A5A5A5 to 0x0000_1003, then read 0x0000_0000 -> returns 0xA5A5A5A5.
- Reset mid-write: accept a write of 0x12345678 to 0x40 with WAIT_CYCLES = 4, then assert rst_i in the 2nd busy cycle. After release, read 0x40 -> returns the prior contents; wr_count_o = 0; dm_busy_o dropped asynchronously with reset.
